// File: rtl/fsqrt_seq_ctrl_if.sv
// rtl/fsqrt_seq_ctrl_if.sv - operand/result valid-ready bundle for fsqrt_seq_ctrl
interface fsqrt_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_s;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;

  modport master (output in_valid, in_s, out_ready, input in_ready, out_valid, out_y);
  modport slave  (input in_valid, in_s, out_ready, output in_ready, out_valid, out_y);
endinterface

// File: rtl/fsqrt_seq_ctrl.sv
// rtl/fsqrt_seq_ctrl.sv - multi-cycle single-precision sqrt sequencer (Newton rsqrt on a shared multiplier)
module fsqrt_seq_ctrl #(
  parameter int ITER = 2
) (
  input  logic            clk,
  input  logic            rstn,
  fsqrt_seq_ctrl_if.slave bus,
  output logic [7:0]      seed_idx,
  input  logic [6:0]      seed_val,
  output logic [31:0]     mul_a,
  output logic [31:0]     mul_b,
  input  logic [63:0]     mul_p,
  output logic            busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEED = 3'd1;
  localparam logic [2:0] S_SQ   = 3'd2;
  localparam logic [2:0] S_MM   = 3'd3;
  localparam logic [2:0] S_XD   = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;
  localparam logic [2:0] S_RND  = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  localparam logic [1:0]  ITER_N = 2'(ITER);
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  logic [2:0]  state;
  logic        armed;
  logic        sign;
  logic [7:0]  e;
  logic [22:0] mant;
  logic [31:0] mp;
  logic [31:0] x;
  logic [31:0] t;
  logic [63:0] p;
  logic [1:0]  cnt;
  logic [31:0] out_y_q;

  logic        is_special;
  logic [31:0] special_y;
  logic [31:0] d;
  logic [22:0] frac;
  logic        rnd_up;
  logic [23:0] frac_r;
  logic signed [8:0] e_half;
  logic [7:0]  exp_base;
  logic [7:0]  exp_r;
  logic [22:0] frac_o;

  // Seed index: odd unbiased exponent selects the [2,4) half of the table.
  assign seed_idx      = {~e[0], mant[22:16]};
  assign bus.in_ready  = armed && (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_y     = out_y_q;
  assign busy          = (state != S_IDLE);

  always_comb begin
    is_special = 1'b1;
    special_y  = QNAN;
    if (e == 8'd0)                        special_y = {sign, 31'd0};
    else if (e == 8'hFF && mant != 23'd0) special_y = QNAN;
    else if (sign)                        special_y = QNAN;
    else if (e == 8'hFF)                  special_y = 32'h7F80_0000;
    else                                  is_special = 1'b0;
  end

  // 3 - t2 in Q2.30; the XD product is then x*(3-t2)/2 once sliced at [62:31].
  assign d = 32'hC000_0000 - {1'b0, t[31:1]};

  always_comb begin
    mul_a = 32'd0;
    mul_b = 32'd0;
    case (state)
      S_SQ:  begin mul_a = x;  mul_b = x; end
      S_MM:  begin mul_a = mp; mul_b = t; end
      S_XD:  begin mul_a = x;  mul_b = d; end
      S_FIN: begin mul_a = mp; mul_b = x; end
      default: ;
    endcase
  end

  assign frac     = p[60:38];
  assign rnd_up   = p[37] & ((|p[36:0]) | p[38]);
  assign frac_r   = {1'b0, frac} + {23'd0, rnd_up};
  assign e_half   = ($signed({1'b0, e}) - 9'sd127) >>> 1;
  assign exp_base = 8'(e_half + 9'sd127);

  // Products outside [1,2) come only from residual iteration error; pin them to the range ends.
  always_comb begin
    frac_o = frac_r[22:0];
    exp_r  = exp_base + {7'd0, frac_r[23]};
    if (p[63] | p[62]) begin
      frac_o = 23'h7F_FFFF;
      exp_r  = exp_base;
    end else if (!p[61]) begin
      frac_o = 23'd0;
      exp_r  = exp_base;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      armed   <= 1'b0;
      sign    <= 1'b0;
      e       <= 8'd0;
      mant    <= 23'd0;
      mp      <= 32'd0;
      x       <= 32'd0;
      t       <= 32'd0;
      p       <= 64'd0;
      cnt     <= 2'd0;
      out_y_q <= 32'd0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE: if (bus.in_valid && armed) begin
          sign  <= bus.in_s[31];
          e     <= bus.in_s[30:23];
          mant  <= bus.in_s[22:0];
          mp    <= bus.in_s[23] ? {2'b01, bus.in_s[22:0], 7'd0} : {1'b1, bus.in_s[22:0], 8'd0};
          cnt   <= 2'd0;
          state <= S_SEED;
        end
        S_SEED: if (is_special) begin
          out_y_q <= special_y;
          state   <= S_DONE;
        end else begin
          x     <= {2'b01, seed_val, 23'd0};
          state <= S_SQ;
        end
        S_SQ: begin
          t     <= mul_p[62:31];
          state <= S_MM;
        end
        S_MM: begin
          t     <= mul_p[61:30];
          state <= S_XD;
        end
        S_XD: begin
          x     <= mul_p[62:31];
          cnt   <= cnt + 2'd1;
          state <= ((cnt + 2'd1) < ITER_N) ? S_SQ : S_FIN;
        end
        S_FIN: begin
          p     <= mul_p;
          state <= S_RND;
        end
        S_RND: begin
          out_y_q <= {1'b0, exp_r, frac_o};
          state   <= S_DONE;
        end
        S_DONE: if (bus.out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
